// File: rtl/sdram_arb_pkg.sv
// Shared types and default widths for the SDRAM CPU-port arbiter.
package sdram_arb_pkg;

   localparam int DEF_AW = 23;
   localparam int DEF_DW = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      REQ_VID = 2'd0,
      REQ_LD  = 2'd1,
      REQ_CPU = 2'd2
   } req_idx_t;

endpackage

// File: rtl/sdram_arb_prio.sv
// Combinational winner picker: video > loader > CPU, with the CPU forced
// once the starve counter has reached STARVE_LIMIT.
module sdram_arb_prio
   import sdram_arb_pkg::*;
#(
   parameter int CW           = 3,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          vid_req,
   input  logic          ld_req,
   input  logic          cpu_req,
   input  logic [CW-1:0] starve_cnt,
   output logic          grant_valid,
   output logic [1:0]    grant_idx
);

   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
      grant_valid = 1'b1;
      grant_idx   = REQ_CPU;
      if (cpu_req && (starve_cnt == CW'(STARVE_LIMIT)))
         grant_idx = REQ_CPU;
      else if (vid_req)
         grant_idx = REQ_VID;
      else if (ld_req)
         grant_idx = REQ_LD;
      else if (!cpu_req)
         grant_valid = 1'b0;
   end

endmodule

// File: rtl/sdram_arbiter.sv
// Registered req/ack scheduler sharing the SDRAM CPU port between video,
// loader and Z80. Optional watchdog on WAIT enabled by SDRAM_ARB_WDOG_EN.
module sdram_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int AW           = DEF_AW,
   parameter int DW           = DEF_DW,
   parameter int STARVE_LIMIT = 4,
   parameter int WDOG_CYCLES  = 255
) (
   input  logic          clk_sys,
   input  logic          reset,
   input  logic          vid_req,
   input  logic [AW-1:0] vid_addr,
   output logic          vid_ack,
   output logic [DW-1:0] vid_dout,
   input  logic          ld_req,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_din,
   output logic          ld_ack,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_din,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_dout,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_din,
   input  logic          mem_ack,
   input  logic [DW-1:0] mem_dout,
   output logic          busy,
   output logic          wdog_err
);

   localparam int SCW = $clog2(STARVE_LIMIT + 2);

   state_t         state;
   logic [1:0]     winner;
   logic [SCW-1:0] starve_cnt;
   logic           grant_valid;
   logic [1:0]     grant_idx;
   logic           wdog_hit;
   logic [DW-1:0]  rd_data;

   sdram_arb_prio #(
      .CW           (SCW),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_prio (
      .vid_req     (vid_req),
      .ld_req      (ld_req),
      .cpu_req     (cpu_req),
      .starve_cnt  (starve_cnt),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   // A watchdog completion returns all-ones instead of controller data.
   assign rd_data = mem_ack ? mem_dout : '1;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         winner     <= REQ_VID;
         starve_cnt <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_din    <= '0;
         vid_ack    <= 1'b0;
         ld_ack     <= 1'b0;
         cpu_ack    <= 1'b0;
         vid_dout   <= '0;
         cpu_dout   <= '0;
         busy       <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register sees pre-edge values.
         mem_req <= 1'b0;
         vid_ack <= 1'b0;
         ld_ack  <= 1'b0;
         cpu_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (!cpu_req)
                  starve_cnt <= '0;
               if (grant_valid) begin
                  winner  <= grant_idx;
                  mem_req <= 1'b1;
                  busy    <= 1'b1;
                  state   <= ISSUE;
                  case (grant_idx)
                     REQ_VID: begin
                        mem_addr <= vid_addr;
                        mem_we   <= 1'b0;
                        mem_din  <= '0;
                     end
                     REQ_LD: begin
                        mem_addr <= ld_addr;
                        mem_we   <= 1'b1;
                        mem_din  <= ld_din;
                     end
                     default: begin
                        mem_addr <= cpu_addr;
                        mem_we   <= cpu_we;
                        mem_din  <= cpu_din;
                     end
                  endcase
                  if (grant_idx == REQ_CPU)
                     starve_cnt <= '0;
                  else if (cpu_req && (starve_cnt < SCW'(STARVE_LIMIT)))
                     starve_cnt <= starve_cnt + 1'b1;
               end
            end
            ISSUE: state <= WAIT;
            WAIT: begin
               if (mem_ack || wdog_hit) begin
                  state <= DONE;
                  case (winner)
                     REQ_VID: begin
                        vid_ack  <= 1'b1;
                        vid_dout <= rd_data;
                     end
                     REQ_LD: ld_ack <= 1'b1;
                     default: begin
                        cpu_ack <= 1'b1;
                        if (!mem_we)
                           cpu_dout <= rd_data;
                     end
                  endcase
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef SDRAM_ARB_WDOG_EN
   localparam int WCW = $clog2(WDOG_CYCLES + 1);

   logic [WCW-1:0] wdog_cnt;

   assign wdog_hit = (state == WAIT) && (wdog_cnt == WCW'(WDOG_CYCLES - 1));

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         wdog_cnt <= '0;
         wdog_err <= 1'b0;
      end else begin
         wdog_cnt <= (state == WAIT) ? wdog_cnt + 1'b1 : '0;
         if (wdog_hit && !mem_ack)
            wdog_err <= 1'b1;
      end
   end
`else
   assign wdog_hit = 1'b0;
   assign wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: expected commands/acks are queued by
// the stimulus and popped by a monitor whenever the DUT strobes mem_req or an ack.
module tb_sdram_arbiter;
   import sdram_arb_pkg::*;

   localparam int AW = 23;
   localparam int DW = 8;
`ifdef SDRAM_ARB_WDOG_EN
   localparam int WDOG = 16;
`else
   localparam int WDOG = 255;
`endif

   logic          clk_sys = 1'b0;
   logic          reset;
   logic          vid_req, ld_req, cpu_req, cpu_we;
   logic [AW-1:0] vid_addr, ld_addr, cpu_addr;
   logic [DW-1:0] ld_din, cpu_din;
   logic          vid_ack, ld_ack, cpu_ack;
   logic [DW-1:0] vid_dout, cpu_dout;
   logic          mem_req, mem_we, mem_ack;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din, mem_dout;
   logic          busy, wdog_err;

   sdram_arbiter #(
      .AW (AW), .DW (DW), .STARVE_LIMIT (4), .WDOG_CYCLES (WDOG)
   ) dut (
      .clk_sys (clk_sys), .reset (reset),
      .vid_req (vid_req), .vid_addr (vid_addr), .vid_ack (vid_ack), .vid_dout (vid_dout),
      .ld_req (ld_req), .ld_addr (ld_addr), .ld_din (ld_din), .ld_ack (ld_ack),
      .cpu_req (cpu_req), .cpu_we (cpu_we), .cpu_addr (cpu_addr), .cpu_din (cpu_din),
      .cpu_ack (cpu_ack), .cpu_dout (cpu_dout),
      .mem_req (mem_req), .mem_we (mem_we), .mem_addr (mem_addr), .mem_din (mem_din),
      .mem_ack (mem_ack), .mem_dout (mem_dout),
      .busy (busy), .wdog_err (wdog_err)
   );

   always #5 clk_sys = ~clk_sys;

   int cyc = 0;
   always @(posedge clk_sys) cyc <= cyc + 1;

   typedef struct {
      logic [AW-1:0] addr;
      logic          we;
      logic [DW-1:0] din;
   } cmd_t;

   typedef struct {
      int            who;
      logic          rd;
      logic [DW-1:0] data;
   } rsp_t;

   cmd_t cmd_q[$];
   rsp_t rsp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   ack_cnt[3];
   bit   ctl_en;
   int   ctl_lat;
   int   stray_cyc;

   function automatic logic [DW-1:0] ctl_data(input logic [AW-1:0] a);
      return a[7:0] ^ 8'hA0;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input cmd_t c, input bit with_rsp, input rsp_t r);
      cmd_q.push_back(c);
      if (with_rsp) rsp_q.push_back(r);
   endtask

   task automatic wait_ack(input int who, input string tag);
      bit got = 1'b0;
      for (int i = 0; i < 400 && !got; i++) begin
         @(negedge clk_sys);
         got = (who == 0) ? vid_ack : (who == 1) ? ld_ack : cpu_ack;
      end
      if (!got) check({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   // Controller model: acks ctl_lat cycles after mem_req, plus an optional stray ack.
   initial begin
      logic [AW-1:0] a;
      mem_ack  = 1'b0;
      mem_dout = '0;
      forever begin
         @(negedge clk_sys);
         if (cyc == stray_cyc) begin
            mem_ack  = 1'b1;
            mem_dout = 8'h77;
            @(negedge clk_sys);
            mem_ack  = 1'b0;
         end else if (mem_req && ctl_en) begin
            a = mem_addr;
            repeat (ctl_lat) @(negedge clk_sys);
            mem_ack  = 1'b1;
            mem_dout = ctl_data(a);
            @(negedge clk_sys);
            mem_ack  = 1'b0;
         end
      end
   end

   // Monitor: pops the scoreboard whenever the DUT presents a command or an ack.
   initial begin
      cmd_t          c;
      rsp_t          r;
      int            who;
      logic [DW-1:0] m_vid, m_cpu;
      m_vid = '0;
      m_cpu = '0;
      forever begin
         @(negedge clk_sys);
         if (reset) begin
            m_vid = '0;
            m_cpu = '0;
         end else begin
            if (mem_req) begin
               if (cmd_q.size() == 0)
                  check("mem_req_unexpected", 32'd1, 32'd0);
               else begin
                  c = cmd_q.pop_front();
                  check("mem_addr", 32'(mem_addr), 32'(c.addr));
                  check("mem_we", 32'(mem_we), 32'(c.we));
                  check("mem_din", 32'(mem_din), 32'(c.din));
               end
            end
            if (vid_ack || ld_ack || cpu_ack) begin
               who = vid_ack ? 0 : ld_ack ? 1 : 2;
               check("ack_onehot", 32'(vid_ack) + 32'(ld_ack) + 32'(cpu_ack), 32'd1);
               if (rsp_q.size() == 0)
                  check("ack_unexpected", 32'(who), 32'd99);
               else begin
                  r = rsp_q.pop_front();
                  check("ack_who", 32'(who), 32'(r.who));
                  if (r.rd && r.who == 0) m_vid = r.data;
                  if (r.rd && r.who == 2) m_cpu = r.data;
                  check("vid_dout", 32'(vid_dout), 32'(m_vid));
                  check("cpu_dout", 32'(cpu_dout), 32'(m_cpu));
               end
               ack_cnt[who]++;
            end
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      int   t0, rel, v0, l0, c0, bad_ack;
      cmd_t c;
      rsp_t r;
      reset = 1'b1;
      {vid_req, ld_req, cpu_req, cpu_we} = '0;
      {vid_addr, ld_addr, cpu_addr} = '0;
      {ld_din, cpu_din} = '0;
      ctl_en = 1'b1; ctl_lat = 3; stray_cyc = -1;
      repeat (3) @(negedge clk_sys);

      // Reset values
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_din", 32'(mem_din), 32'd0);
      check("rst_acks", 32'({vid_ack, ld_ack, cpu_ack}), 32'd0);
      check("rst_douts", 32'({vid_dout, cpu_dout}), 32'd0);
      check("rst_wdog", 32'(wdog_err), 32'd0);
      check("rst_starve", 32'(dut.starve_cnt), 32'd0);
      check("rst_state", 32'(dut.state), 32'(IDLE));
      reset = 1'b0;
      @(negedge clk_sys);

      // CPU read alone: mem_req at 1, ack at 5, busy low by 7
      cpu_addr = 23'h10005; cpu_we = 1'b0; cpu_din = 8'h00; cpu_req = 1'b1;
      c = '{23'h10005, 1'b0, 8'h00}; r = '{2, 1'b1, 8'hA5}; push(c, 1'b1, r);
      t0 = cyc;
      @(negedge clk_sys);
      check("t1_mreq_cycle1", 32'(mem_req), 32'd1);
      wait_ack(2, "t1_cpu_ack");
      check("t1_ack_cycle", 32'(cyc - t0), 32'd5);
      check("t1_cpu_dout", 32'(cpu_dout), 32'hA5);
      cpu_req = 1'b0;
      while (cyc < t0 + 7) @(negedge clk_sys);
      check("t1_busy_low", 32'(busy), 32'd0);

      // Simultaneous requests: video, loader, then CPU
      v0 = ack_cnt[0]; l0 = ack_cnt[1]; c0 = ack_cnt[2];
      vid_addr = 23'h00123; ld_addr = 23'h00456; ld_din = 8'h99; cpu_addr = 23'h00789;
      c = '{23'h00123, 1'b0, 8'h00}; r = '{0, 1'b1, 8'h83}; push(c, 1'b1, r);
      c = '{23'h00456, 1'b1, 8'h99}; r = '{1, 1'b0, 8'h00}; push(c, 1'b1, r);
      c = '{23'h00789, 1'b0, 8'h00}; r = '{2, 1'b1, 8'h29}; push(c, 1'b1, r);
      vid_req = 1'b1; ld_req = 1'b1; cpu_req = 1'b1;
      wait_ack(0, "t2_vid"); vid_req = 1'b0;
      wait_ack(1, "t2_ld");  ld_req = 1'b0;
      wait_ack(2, "t2_cpu"); cpu_req = 1'b0;
      repeat (6) @(negedge clk_sys);
      check("t2_vid_once", 32'(ack_cnt[0] - v0), 32'd1);
      check("t2_ld_once", 32'(ack_cnt[1] - l0), 32'd1);
      check("t2_cpu_once", 32'(ack_cnt[2] - c0), 32'd1);

      // Starvation: CPU forced on the 5th arbitration
      v0 = ack_cnt[0]; l0 = ack_cnt[1];
      vid_addr = 23'h00200; cpu_addr = 23'h00ABC;
      for (int i = 0; i < 4; i++) begin
         c = '{23'h00200, 1'b0, 8'h00}; r = '{0, 1'b1, 8'hA0}; push(c, 1'b1, r);
      end
      c = '{23'h00ABC, 1'b0, 8'h00}; r = '{2, 1'b1, 8'h1C}; push(c, 1'b1, r);
      vid_req = 1'b1; ld_req = 1'b1; cpu_req = 1'b1;
      wait_ack(2, "t3_cpu");
      vid_req = 1'b0; ld_req = 1'b0; cpu_req = 1'b0;
      check("t3_starve_clear", 32'(dut.starve_cnt), 32'd0);
      check("t3_vid_grants", 32'(ack_cnt[0] - v0), 32'd4);
      check("t3_ld_grants", 32'(ack_cnt[1] - l0), 32'd0);
      repeat (3) @(negedge clk_sys);

      // Loader write and CPU write leave dout registers alone
      ld_addr = 23'h40000; ld_din = 8'h3C;
      c = '{23'h40000, 1'b1, 8'h3C}; r = '{1, 1'b0, 8'h00}; push(c, 1'b1, r);
      ld_req = 1'b1;
      wait_ack(1, "t4_ld"); ld_req = 1'b0;
      check("t4_vid_dout_kept", 32'(vid_dout), 32'hA0);
      check("t4_cpu_dout_kept", 32'(cpu_dout), 32'h1C);
      cpu_addr = 23'h00055; cpu_din = 8'hE7; cpu_we = 1'b1;
      c = '{23'h00055, 1'b1, 8'hE7}; r = '{2, 1'b0, 8'h00}; push(c, 1'b1, r);
      cpu_req = 1'b1;
      wait_ack(2, "t4_cpu_wr"); cpu_req = 1'b0; cpu_we = 1'b0;
      check("t4_cpu_wr_dout", 32'(cpu_dout), 32'h1C);
      repeat (3) @(negedge clk_sys);

      // Reset during WAIT, stray mem_ack afterwards
      ctl_en = 1'b0;
      cpu_addr = 23'h00077; cpu_din = 8'h00;
      c = '{23'h00077, 1'b0, 8'h00}; push(c, 1'b0, r);
      cpu_req = 1'b1;
      repeat (2) @(negedge clk_sys);
      check("t5_in_wait", 32'(dut.state), 32'(WAIT));
      #2 reset = 1'b1;
      #1;
      check("t5_async_state", 32'(dut.state), 32'(IDLE));
      check("t5_async_busy", 32'(busy), 32'd0);
      cpu_req = 1'b0;
      repeat (2) @(negedge clk_sys);
      reset = 1'b0;
      rel = cyc;
      stray_cyc = rel + 2;
      bad_ack = 0;
      repeat (6) begin
         @(negedge clk_sys);
         bad_ack += int'(vid_ack) + int'(ld_ack) + int'(cpu_ack);
      end
      check("t5_no_ack", 32'(bad_ack), 32'd0);
      check("t5_state", 32'(dut.state), 32'(IDLE));
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_cpu_dout", 32'(cpu_dout), 32'd0);
      stray_cyc = -1;

`ifdef SDRAM_ARB_WDOG_EN
      // Watchdog: no mem_ack, CPU read completes with all-ones
      cpu_addr = 23'h00011;
      c = '{23'h00011, 1'b0, 8'h00}; r = '{2, 1'b1, 8'hFF}; push(c, 1'b1, r);
      cpu_req = 1'b1;
      t0 = cyc;
      wait_ack(2, "t6_wdog");
      cpu_req = 1'b0;
      check("t6_ack_cycle", 32'(cyc - t0), 32'd18);
      check("t6_cpu_dout", 32'(cpu_dout), 32'hFF);
      check("t6_wdog_set", 32'(wdog_err), 32'd1);
      repeat (10) @(negedge clk_sys);
      check("t6_wdog_sticky", 32'(wdog_err), 32'd1);
      reset = 1'b1;
      repeat (2) @(negedge clk_sys);
      reset = 1'b0;
      check("t6_wdog_cleared", 32'(wdog_err), 32'd0);
`else
      // Without the watchdog WAIT holds indefinitely
      cpu_addr = 23'h00033;
      c = '{23'h00033, 1'b0, 8'h00}; push(c, 1'b0, r);
      cpu_req = 1'b1;
      bad_ack = 0;
      repeat (300) begin
         @(negedge clk_sys);
         bad_ack += int'(cpu_ack);
      end
      cpu_req = 1'b0;
      check("t6_stall_no_ack", 32'(bad_ack), 32'd0);
      check("t6_stall_state", 32'(dut.state), 32'(WAIT));
      check("t6_stall_busy", 32'(busy), 32'd1);
      check("t6_wdog_zero", 32'(wdog_err), 32'd0);
      reset = 1'b1;
      repeat (2) @(negedge clk_sys);
      reset = 1'b0;
`endif
      ctl_en = 1'b1;
      repeat (3) @(negedge clk_sys);
      check("end_cmd_q_empty", 32'(cmd_q.size()), 32'd0);
      check("end_rsp_q_empty", 32'(rsp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
